dmem_arbiter: RTL
=================

# dmem_arbiter

Arbitrates the processor's single data-memory port between the core's load/store path and a host port used for loading and inspecting memory. The core has priority. A pending host access is served when the core is idle, or after a bounded wait, by stalling the core for one cycle. It sits between the processor's datapath (`dataadr`, `writedata`, `memwrite`) and the data memory. It drives the stall that freezes the PC and register-file write.

## Interface
- `ADDR_W`, 32, address width (byte address, passed through unchanged)
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, cycles a host request may wait behind core traffic before a forced grant; legal 1..255
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `cpu_re`  in  1  core load this cycle
- `cpu_we`  in  1  core store this cycle (`memwrite`)
- `cpu_addr`  in  ADDR_W  core address (`dataadr`)
- `cpu_wdata`  in  DATA_W  core store data (`writedata`)
- `cpu_rdata`  out  DATA_W  load data to core
- `cpu_stall`  out  1  core must hold PC and suppress register write this cycle
- `host_req`  in  1  host access pending; held with addr/wdata/we stable until `host_ack`
- `host_we`  in  1  host write (1) / read (0)
- `host_addr`  in  ADDR_W  host address
- `host_wdata`  in  DATA_W  host write data
- `host_ack`  out  1  one-cycle pulse: host access performed this cycle
- `host_rdata`  out  DATA_W  read data, valid when `host_ack`=1
- `mem_addr`  out  ADDR_W  to data memory
- `mem_wdata`  out  DATA_W  to data memory
- `mem_we`  out  1  to data memory (write on next rising edge)
- `mem_rdata`  in  DATA_W  combinational read data from memory

## Operation
- `cpu_req = cpu_re | cpu_we`.
- Registered FSM with states IDLE, WAIT and HOST, plus an 8-bit `wait_cnt`.
- IDLE:
  - Memory bus = core signals; `mem_we = cpu_we`.
  - `host_req & !cpu_req` → HOST.
  - `host_req & cpu_req` → WAIT, with `wait_cnt` = 0.
  - Otherwise stay in IDLE.
- WAIT:
  - Bus = core signals.
  - `wait_cnt` increments each cycle.
  - Go to HOST when `!cpu_req`, or when `wait_cnt == MAX_WAIT-1`.
  - If `host_req` drops, return to IDLE; dropping a request before its ack is a protocol violation.
- HOST:
  - Bus = host signals; `mem_we = host_we`.
  - `host_ack` = 1 and `host_rdata = mem_rdata`.
  - `cpu_stall = cpu_req`, so a core access in this cycle is blocked; `mem_we` never reflects `cpu_we`.
  - Always → IDLE.
- `cpu_rdata = mem_rdata` in all states (don't-care when stalled).
- `cpu_stall` is 0 outside HOST.
- Back-to-back host requests: after HOST, one IDLE cycle is re-evaluated, so at most one host access per two cycles.

## Timing
- Reset values (`reset`=0, asynchronous): state IDLE, `wait_cnt` 0, `host_ack` 0, `cpu_stall` 0, `mem_we` forced 0.
- Bus mux outputs are combinational from the state and inputs.
- `host_ack` latency from `host_req` rising while idle with no core traffic: 1 cycle (HOST in the next cycle).
- Worst-case latency under continuous core traffic: MAX_WAIT+1 cycles.
- Core sees at most one stall cycle per host access, and no two consecutive stall cycles.
- Reset mid-HOST: the access is aborted, no ack is produced, and the host must re-request.
- Writes commit on the rising edge that ends the granted cycle.

## Configuration
- `DMEM_ARB_STATS_EN`
- Defined: adds output `stall_cnt` (32 bits, reset 0). It increments on every cycle with `cpu_stall`=1 and saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset held low with `cpu_we`=1 → `mem_we`=0, `cpu_stall`=0, `host_ack`=0; after release, `cpu_we`=1, addr 0x54, data 7 → memory[0x54]=7.
- Host write to 0x40, data 0xDEADBEEF, no core traffic → `host_ack` exactly 1 cycle after `host_req`, `cpu_stall` stays 0; host read of 0x40 returns 0xDEADBEEF.
- Core load every cycle, `host_req` asserted with MAX_WAIT=4 → ack on the 5th cycle after the request, `cpu_stall`=1 that cycle only, core load repeated correctly on the following cycle.
- Core store in the forced-grant cycle, `cpu_we`=1 to 0x10 with data 5 → memory[0x10] unchanged that cycle, written next cycle; host data stored at its own address.
- `reset` asserted in the HOST cycle → no `host_ack`, state IDLE; re-request is acked after 1 cycle.
- With `DMEM_ARB_STATS_EN`: three forced grants under continuous core traffic → `stall_cnt`=3.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the three buses that meet at the data-memory arbiter.
//   cpu_*  : core load/store path (dataadr / writedata / memwrite)
//   host_* : host load/inspect port with req/ack handshake
//   mem_*  : single port of the data memory
// The slave modport is the arbiter's view; master is the surrounding system
// (core, host and memory together).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // core side
  logic              cpu_re;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  // host side
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core and a
// host port. The core owns the bus by default; a pending host access is
// granted as soon as the core is idle, or after MAX_WAIT cycles of waiting
// behind core traffic, in which case the core is stalled for exactly one
// cycle and repeats its access on the following cycle.
//
// Optional build macro DMEM_ARB_STATS_EN adds a saturating 32-bit counter
// of core stall cycles on output stall_cnt.
module dmem_arbiter #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4    // legal 1..255
) (
  input  logic           clk,
  input  logic           reset,          // asynchronous, active low
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOST = 2'd2
  } arb_state_t;

  // Value of wait_cnt in the last WAIT cycle before a forced grant.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_nxt;

  logic              cpu_req;
  logic              sel_host;
  logic              stall;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;

  assign cpu_req = bus.cpu_re | bus.cpu_we;

  // State and wait counter registers; reset aborts any grant in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: core priority, bounded wait for the host.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    sel_host     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.host_req) begin
          if (cpu_req) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = 8'd0;
          end else begin
            state_nxt = S_HOST;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt + 8'd1;
        if (!bus.host_req) begin
          // host withdrew its request; not a legal handshake, just recover
          state_nxt = S_IDLE;
        end else if (!cpu_req || (wait_cnt == WAIT_LAST)) begin
          state_nxt = S_HOST;
        end
      end
      S_HOST: begin
        sel_host  = 1'b1;
        // always drop back to IDLE so the core gets at least one cycle
        // between two host grants
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus multiplexer: the host only owns the memory port in the HOST cycle.
  always_comb begin
    bus_addr  = bus.cpu_addr;
    bus_wdata = bus.cpu_wdata;
    bus_we    = bus.cpu_we;
    if (sel_host) begin
      bus_addr  = bus.host_addr;
      bus_wdata = bus.host_wdata;
      bus_we    = bus.host_we;
    end
  end

  // A core access coinciding with the host grant is blocked and must repeat.
  assign stall = sel_host & cpu_req;

  assign bus.mem_addr   = bus_addr;
  assign bus.mem_wdata  = bus_wdata;
  // Write enable is forced low while reset is held, independent of the core.
  assign bus.mem_we     = reset & bus_we;

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = stall;
  assign bus.host_ack   = sel_host;
  assign bus.host_rdata = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (&val) ? val : val + 32'd1;
  endfunction

  // Count core stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
